// File: rtl/mxint8_add_sub_sched_pkg.sv
// Shared definitions for the MXINT8 add/sub scheduler slice.
// - Block format constants: scale width, element width, elements per block,
//   requester id width.
// - op_t: one operation as stored in pipeline stage S1.
// - sat_element: clamps a widened lane result back into a signed element.
package mxint8_add_sub_sched_pkg;

  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int BLOCK_SIZE           = 4;
  localparam int MXINT8_REQ_ID_WIDTH  = 1;

  localparam int ELEMENTS_WIDTH = MXINT8_ELEMENT_WIDTH * BLOCK_SIZE;
  // Two extra bits hold any sum or difference of two aligned elements.
  localparam int SUM_WIDTH      = MXINT8_ELEMENT_WIDTH + 2;

  typedef struct packed {
    logic                           is_add;
    logic [SCALE_WIDTH-1:0]         scale_a;
    logic [ELEMENTS_WIDTH-1:0]      elements_a;
    logic [SCALE_WIDTH-1:0]         scale_b;
    logic [ELEMENTS_WIDTH-1:0]      elements_b;
    logic [MXINT8_REQ_ID_WIDTH-1:0] id;
  } op_t;

  // Saturate a signed lane result to the signed element range.
  function automatic logic [MXINT8_ELEMENT_WIDTH-1:0] sat_element(
    input logic signed [SUM_WIDTH-1:0] v
  );
    logic signed [SUM_WIDTH-1:0] max_v;
    logic signed [SUM_WIDTH-1:0] min_v;
    max_v = {{(SUM_WIDTH-MXINT8_ELEMENT_WIDTH+1){1'b0}}, {(MXINT8_ELEMENT_WIDTH-1){1'b1}}};
    min_v = {{(SUM_WIDTH-MXINT8_ELEMENT_WIDTH+1){1'b1}}, {(MXINT8_ELEMENT_WIDTH-1){1'b0}}};
    if (v > max_v) begin
      sat_element = {1'b0, {(MXINT8_ELEMENT_WIDTH-1){1'b1}}};
    end else if (v < min_v) begin
      sat_element = {1'b1, {(MXINT8_ELEMENT_WIDTH-1){1'b0}}};
    end else begin
      sat_element = v[MXINT8_ELEMENT_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mxint8_add_sub.sv
// Combinational MXINT8 block add/subtract.
// Both blocks are aligned to the larger scale: elements of the block with the
// smaller scale are arithmetically shifted right by the scale difference
// (shifts of element-width-1 or more leave only the sign). Each lane then
// computes A+B or A-B and saturates to the signed element range. The result
// scale is the larger input scale.
// Ports:
//   i_is_add      1 = A+B, 0 = A-B
//   i_scale_a/b   shared scale of block A / B
//   i_elements_a/b  packed signed elements, lane k at [k*EW +: EW]
//   o_scale       result scale
//   o_elements    result elements
module mxint8_add_sub
  import mxint8_add_sub_sched_pkg::*;
(
  input  logic                      i_is_add,
  input  logic [SCALE_WIDTH-1:0]    i_scale_a,
  input  logic [ELEMENTS_WIDTH-1:0] i_elements_a,
  input  logic [SCALE_WIDTH-1:0]    i_scale_b,
  input  logic [ELEMENTS_WIDTH-1:0] i_elements_b,
  output logic [SCALE_WIDTH-1:0]    o_scale,
  output logic [ELEMENTS_WIDTH-1:0] o_elements
);

  localparam int EW  = MXINT8_ELEMENT_WIDTH;
  localparam int SHW = $clog2(EW);

  logic [SCALE_WIDTH-1:0] scale_max;
  logic [SCALE_WIDTH-1:0] diff_a;
  logic [SCALE_WIDTH-1:0] diff_b;
  logic [SHW-1:0]         shift_a;
  logic [SHW-1:0]         shift_b;

  assign scale_max = (i_scale_a >= i_scale_b) ? i_scale_a : i_scale_b;
  assign diff_a    = scale_max - i_scale_a;
  assign diff_b    = scale_max - i_scale_b;

  // Cap the shift: beyond EW-1 every bit is already the sign.
  assign shift_a = (diff_a >= SCALE_WIDTH'(EW-1)) ? SHW'(EW-1) : diff_a[SHW-1:0];
  assign shift_b = (diff_b >= SCALE_WIDTH'(EW-1)) ? SHW'(EW-1) : diff_b[SHW-1:0];

  assign o_scale = scale_max;

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_lane
    logic signed [EW-1:0]        a_al;
    logic signed [EW-1:0]        b_al;
    logic signed [SUM_WIDTH-1:0] a_ext;
    logic signed [SUM_WIDTH-1:0] b_ext;
    logic signed [SUM_WIDTH-1:0] sum;

    assign a_al  = $signed(i_elements_a[k*EW +: EW]) >>> shift_a;
    assign b_al  = $signed(i_elements_b[k*EW +: EW]) >>> shift_b;
    assign a_ext = {{(SUM_WIDTH-EW){a_al[EW-1]}}, a_al};
    assign b_ext = {{(SUM_WIDTH-EW){b_al[EW-1]}}, b_al};
    assign sum   = i_is_add ? (a_ext + b_ext) : (a_ext - b_ext);
    assign o_elements[k*EW +: EW] = sat_element(sum);
  end

endmodule

// File: rtl/mxint8_add_sub_sched.sv
// Two-requester scheduler around one shared mxint8_add_sub datapath.
// Requests are arbitrated (round-robin or fixed priority, R0 first), the
// winner is registered into S1, the datapath works from S1 and its result is
// registered into S2, which drives the result stream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands until they see ready; ready
// is only ever high for one requester per cycle. The result side holds
// o_valid and all result fields stable while o_valid is high and i_ready low.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rN_valid / o_rN_ready   request handshake, N = 0, 1
//   i_rN_is_add               1 = A+B, 0 = A-B
//   i_rN_scale_a/b, i_rN_elements_a/b  operand blocks
//   o_valid / i_ready         result handshake
//   o_id                      requester that issued the result
//   o_scale, o_elements       result block
//   o_busy                    S1 or S2 holds an operation
//   o_op_count                results handed off (wraps)
module mxint8_add_sub_sched
  import mxint8_add_sub_sched_pkg::*;
#(
  parameter bit RR_ENABLE   = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_r0_valid,
  output logic                           o_r0_ready,
  input  logic                           i_r0_is_add,
  input  logic [SCALE_WIDTH-1:0]         i_r0_scale_a,
  input  logic [ELEMENTS_WIDTH-1:0]      i_r0_elements_a,
  input  logic [SCALE_WIDTH-1:0]         i_r0_scale_b,
  input  logic [ELEMENTS_WIDTH-1:0]      i_r0_elements_b,
  input  logic                           i_r1_valid,
  output logic                           o_r1_ready,
  input  logic                           i_r1_is_add,
  input  logic [SCALE_WIDTH-1:0]         i_r1_scale_a,
  input  logic [ELEMENTS_WIDTH-1:0]      i_r1_elements_a,
  input  logic [SCALE_WIDTH-1:0]         i_r1_scale_b,
  input  logic [ELEMENTS_WIDTH-1:0]      i_r1_elements_b,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [MXINT8_REQ_ID_WIDTH-1:0] o_id,
  output logic [SCALE_WIDTH-1:0]         o_scale,
  output logic [ELEMENTS_WIDTH-1:0]      o_elements,
  output logic                           o_busy,
  output logic [COUNT_WIDTH-1:0]         o_op_count
);

  logic                      s1_v;
  op_t                       s1_op;
  logic                      s2_v;
  logic                      rr_ptr;
  logic                      adv1;
  logic                      adv2;
  logic [1:0]                grant;
  logic                      take;
  op_t                       req_op;
  logic [SCALE_WIDTH-1:0]    dp_scale;
  logic [ELEMENTS_WIDTH-1:0] dp_elements;

  // S2 can load when empty or draining; S1 can load when empty or moving on.
  assign adv2 = !s2_v || i_ready;
  assign adv1 = !s1_v || adv2;

  // On a tie, round-robin grants the requester that did not win last;
  // the pointer resets to 0 so R1 takes the first tie.
  always_comb begin
    grant = 2'b00;
    if (i_r0_valid && i_r1_valid) begin
      if (RR_ENABLE && !rr_ptr) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else if (i_r0_valid) begin
      grant = 2'b01;
    end else if (i_r1_valid) begin
      grant = 2'b10;
    end
  end

  assign o_r0_ready = grant[0] && adv1 && i_rst_n;
  assign o_r1_ready = grant[1] && adv1 && i_rst_n;
  assign take       = o_r0_ready || o_r1_ready;

  always_comb begin
    req_op = '0;
    if (grant[1]) begin
      req_op.is_add     = i_r1_is_add;
      req_op.scale_a    = i_r1_scale_a;
      req_op.elements_a = i_r1_elements_a;
      req_op.scale_b    = i_r1_scale_b;
      req_op.elements_b = i_r1_elements_b;
      req_op.id         = MXINT8_REQ_ID_WIDTH'(1);
    end else begin
      req_op.is_add     = i_r0_is_add;
      req_op.scale_a    = i_r0_scale_a;
      req_op.elements_a = i_r0_elements_a;
      req_op.scale_b    = i_r0_scale_b;
      req_op.elements_b = i_r0_elements_b;
      req_op.id         = MXINT8_REQ_ID_WIDTH'(0);
    end
  end

  mxint8_add_sub u_add_sub (
    .i_is_add     (s1_op.is_add),
    .i_scale_a    (s1_op.scale_a),
    .i_elements_a (s1_op.elements_a),
    .i_scale_b    (s1_op.scale_b),
    .i_elements_b (s1_op.elements_b),
    .o_scale      (dp_scale),
    .o_elements   (dp_elements)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v       <= 1'b0;
      s1_op      <= '0;
      s2_v       <= 1'b0;
      o_id       <= '0;
      o_scale    <= '0;
      o_elements <= '0;
      rr_ptr     <= 1'b0;
      o_op_count <= '0;
    end else begin
      if (adv1) begin
        s1_v <= take;
        if (take) begin
          s1_op <= req_op;
        end
      end
      // S2 follows S1 whenever it may advance; an empty S1 clears it.
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          o_id       <= s1_op.id;
          o_scale    <= dp_scale;
          o_elements <= dp_elements;
        end
      end
      if (take) begin
        rr_ptr <= grant[1];
      end
      if (s2_v && i_ready) begin
        o_op_count <= o_op_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign o_valid = s2_v;
  assign o_busy  = s1_v || s2_v;

endmodule
